// File: rtl/rate_limiter_mc_if.sv
// Handshake/config/status bundle between the config writer and the multi-channel limiter.
interface rate_limiter_mc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_WIDTH = 4,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                         in_valid;
  logic                         in_ready;
  logic [CH_W-1:0]              in_ch;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         tick;
  logic [STEP_WIDTH-1:0]        rise_step;
  logic [STEP_WIDTH-1:0]        fall_step;
  logic                         bypass;
  logic                         clr_overrun;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic                         upd_valid;
  logic [CH_W-1:0]              upd_ch;
  logic [NUM_CH-1:0]            settled;
  logic                         busy;
  logic                         overrun;

  modport master (
    output in_valid, in_ch, in_data, tick, rise_step, fall_step, bypass, clr_overrun,
    input  in_ready, data_out, upd_valid, upd_ch, settled, busy, overrun
  );

  modport slave (
    input  in_valid, in_ch, in_data, tick, rise_step, fall_step, bypass, clr_overrun,
    output in_ready, data_out, upd_valid, upd_ch, settled, busy, overrun
  );
endinterface

// File: rtl/rate_limiter_mc.sv
// Multi-channel rate limiter: per-channel target/output lanes plus one shared
// serial slew engine that visits every channel once per tick.

// Combinational slew of one sample toward its target, clamped, no wrap.
module rate_limiter_mc_slew #(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic [DATA_WIDTH-1:0] tgt,
  input  logic [STEP_WIDTH-1:0] rise_step,
  input  logic [STEP_WIDTH-1:0] fall_step,
  input  logic                  bypass,
  output logic [DATA_WIDTH-1:0] nxt
);
  logic [DATA_WIDTH:0] diff;
  logic [DATA_WIDTH:0] rise_x;
  logic [DATA_WIDTH:0] fall_x;

  assign rise_x = (DATA_WIDTH+1)'(rise_step);
  assign fall_x = (DATA_WIDTH+1)'(fall_step);

  // Extra bit on the distance keeps the compare free of wrap; the partial
  // step branch is only taken when the step is strictly smaller than the gap.
  always_comb begin
    nxt  = cur;
    diff = '0;
    if (bypass) begin
      nxt = tgt;
    end else if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      nxt  = (diff <= rise_x) ? tgt : cur + DATA_WIDTH'(rise_step);
    end else if (tgt < cur) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      nxt  = (diff <= fall_x) ? tgt : cur - DATA_WIDTH'(fall_step);
    end
  end
endmodule

// One channel: target register, output register and registered settled flag.
module rate_limiter_mc_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  upd_en,
  input  logic [DATA_WIDTH-1:0] upd_data,
  output logic [DATA_WIDTH-1:0] tgt,
  output logic [DATA_WIDTH-1:0] cur,
  output logic                  settled
);
  // Target only changes on an accepted write.
  always_ff @(posedge clk) begin
    if (reset)      tgt <= '0;
    else if (wr_en) tgt <= wr_data;
  end

  // Output only changes in this channel's sweep slot.
  always_ff @(posedge clk) begin
    if (reset)       cur <= '0;
    else if (upd_en) cur <= upd_data;
  end

  // Settled trails any change of cur/tgt by one cycle.
  always_ff @(posedge clk) begin
    if (reset) settled <= 1'b1;
    else       settled <= (cur == tgt);
  end
endmodule

module rate_limiter_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int STEP_WIDTH = 4,
  parameter int NUM_CH     = 4
) (
  input logic               clk,
  input logic               reset,
  rate_limiter_mc_if.slave  bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                             state_q, state_d;
  logic [CH_W-1:0]                    ptr_q;
  logic                               busy;
  logic                               in_ready;
  logic                               wr_fire;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  tgt_q;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  cur_q;
  logic [NUM_CH-1:0]                  settled_q;
  logic [DATA_WIDTH-1:0]              slew_nxt;
  logic                               upd_valid_q;
  logic [CH_W-1:0]                    upd_ch_q;
  logic                               overrun_q;

  // State register and sweep pointer; pointer wraps to 0 as the sweep ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SWEEP) ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + CH_W'(1);
    end
  end

  // Next state: a tick starts a sweep only from IDLE; sweep ends after the last channel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.tick)      state_d = SWEEP;
      SWEEP:   if (ptr_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: writes are only accepted while idle and out of reset.
  always_comb begin
    busy     = (state_q == SWEEP);
    in_ready = ~busy & ~reset;
    wr_fire  = bus.in_valid & in_ready;
  end

  // Single shared slew engine looks at the channel under the pointer.
  rate_limiter_mc_slew #(.DATA_WIDTH(DATA_WIDTH), .STEP_WIDTH(STEP_WIDTH)) u_slew (
    .cur       (cur_q[ptr_q]),
    .tgt       (tgt_q[ptr_q]),
    .rise_step (bus.rise_step),
    .fall_step (bus.fall_step),
    .bypass    (bus.bypass),
    .nxt       (slew_nxt)
  );

  // Out-of-range write channels match no lane and are silently dropped.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    rate_limiter_mc_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_fire && (bus.in_ch == CH_W'(k))),
      .wr_data  (bus.in_data),
      .upd_en   (busy && (ptr_q == CH_W'(k))),
      .upd_data (slew_nxt),
      .tgt      (tgt_q[k]),
      .cur      (cur_q[k]),
      .settled  (settled_q[k])
    );
  end

  // Update strobe lands together with the new output value of the swept channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
    end else begin
      upd_valid_q <= busy;
      upd_ch_q    <= ptr_q;
    end
  end

  // Sticky overrun; a new overrun beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)                 overrun_q <= 1'b0;
    else if (bus.tick && busy) overrun_q <= 1'b1;
    else if (bus.clr_overrun)  overrun_q <= 1'b0;
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = busy;
  assign bus.data_out  = cur_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_ch    = upd_ch_q;
  assign bus.settled   = settled_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_rate_limiter_mc.sv
// Directed bench for rate_limiter_mc: a cycle-by-cycle vector table for handshake,
// sweep timing and overrun, then hand sequences for slewing, clamping and reset.
module tb_rate_limiter_mc;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic reset;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  rate_limiter_mc_if #(.DATA_WIDTH(DW), .STEP_WIDTH(SW), .NUM_CH(NC)) bus ();

  rate_limiter_mc #(.DATA_WIDTH(DW), .STEP_WIDTH(SW), .NUM_CH(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        vld;
    logic [1:0]  ch;
    logic [7:0]  data;
    logic        tick;
    logic        clr;
    logic        busy;
    logic        uv;
    logic [1:0]  uch;
    logic        rdy;
    logic        ovr;
    logic [3:0]  stl;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic vld, logic [1:0] ch, logic [7:0] data, logic tick,
                              logic clr, logic busy, logic uv, logic [1:0] uch, logic rdy,
                              logic ovr, logic [3:0] stl, logic [31:0] dout);
    vec_t v;
    v.vld = vld; v.ch = ch; v.data = data; v.tick = tick; v.clr = clr;
    v.busy = busy; v.uv = uv; v.uch = uch; v.rdy = rdy; v.ovr = ovr; v.stl = stl; v.dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 0; bus.in_ch = 0; bus.in_data = 0; bus.tick = 0; bus.clr_overrun = 0;
  endtask

  task automatic write_tgt(input logic [1:0] ch, input logic [7:0] d);
    bus.in_valid = 1; bus.in_ch = ch; bus.in_data = d;
    step();
    bus.in_valid = 0;
  endtask

  // One full sweep; waits (bounded) until the engine goes idle again.
  task automatic sweep();
    int n;
    bus.tick = 1;
    step();
    bus.tick = 0;
    n = 0;
    while (bus.busy && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("sweep_timeout", 32'(n), 32'd0);
  endtask

  function automatic logic [7:0] ch_val(input int k);
    logic [31:0] d;
    d = bus.data_out;
    return d[k*8 +: 8];
  endfunction

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    int e;
    idle_inputs();
    bus.rise_step = 4; bus.fall_step = 4; bus.bypass = 0;
    reset = 1;
    step();
    step();
    // reset values while reset is held
    chk("rst_busy",     32'(bus.busy),      32'd0);
    chk("rst_upd",      32'(bus.upd_valid), 32'd0);
    chk("rst_settled",  32'(bus.settled),   32'hF);
    chk("rst_dout",     bus.data_out,       32'd0);
    chk("rst_overrun",  32'(bus.overrun),   32'd0);
    chk("rst_in_ready", 32'(bus.in_ready),  32'd0);
    reset = 0;
    #1;
    chk("rdy_after_rst", 32'(bus.in_ready), 32'd1);

    // vld ch data tick clr | busy uv uch rdy ovr settled data_out
    tbl[0]  = mk(1, 2, 10, 0, 0,  0, 0, 0, 1, 0, 4'b1111, 32'h0000_0000);
    tbl[1]  = mk(0, 0, 0,  1, 0,  1, 0, 0, 0, 0, 4'b1011, 32'h0000_0000);
    tbl[2]  = mk(0, 0, 0,  0, 0,  1, 1, 0, 0, 0, 4'b1011, 32'h0000_0000);
    tbl[3]  = mk(0, 0, 0,  1, 0,  1, 1, 1, 0, 1, 4'b1011, 32'h0000_0000);
    tbl[4]  = mk(1, 0, 7,  0, 0,  1, 1, 2, 0, 1, 4'b1011, 32'h0004_0000);
    tbl[5]  = mk(1, 0, 7,  0, 0,  0, 1, 3, 1, 1, 4'b1011, 32'h0004_0000);
    tbl[6]  = mk(1, 0, 7,  0, 1,  0, 0, 0, 1, 0, 4'b1011, 32'h0004_0000);
    tbl[7]  = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 0, 4'b1010, 32'h0004_0000);
    tbl[8]  = mk(0, 0, 0,  1, 1,  1, 0, 0, 0, 0, 4'b1010, 32'h0004_0000);
    tbl[9]  = mk(0, 0, 0,  1, 1,  1, 1, 0, 0, 1, 4'b1010, 32'h0004_0004);
    tbl[10] = mk(0, 0, 0,  0, 1,  1, 1, 1, 0, 0, 4'b1010, 32'h0004_0004);
    tbl[11] = mk(0, 0, 0,  0, 0,  1, 1, 2, 0, 0, 4'b1010, 32'h0008_0004);
    tbl[12] = mk(0, 0, 0,  0, 0,  0, 1, 3, 1, 0, 4'b1010, 32'h0008_0004);
    tbl[13] = mk(0, 0, 0,  0, 0,  0, 0, 0, 1, 0, 4'b1010, 32'h0008_0004);

    // table: apply one row per cycle and compare every output afterwards
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = tbl[i].vld; bus.in_ch = tbl[i].ch; bus.in_data = tbl[i].data;
      bus.tick = tbl[i].tick; bus.clr_overrun = tbl[i].clr;
      step();
      chk($sformatf("v%0d_busy", i),     32'(bus.busy),      32'(tbl[i].busy));
      chk($sformatf("v%0d_upd_valid", i), 32'(bus.upd_valid), 32'(tbl[i].uv));
      chk($sformatf("v%0d_upd_ch", i),   32'(bus.upd_ch),    32'(tbl[i].uch));
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready),  32'(tbl[i].rdy));
      chk($sformatf("v%0d_overrun", i),  32'(bus.overrun),   32'(tbl[i].ovr));
      chk($sformatf("v%0d_settled", i),  32'(bus.settled),   32'(tbl[i].stl));
      chk($sformatf("v%0d_data_out", i), bus.data_out,       tbl[i].dout);
    end
    idle_inputs();

    // ch1 ramps up by 5 to 200 and then holds
    do_reset();
    bus.rise_step = 5; bus.fall_step = 0; bus.bypass = 0;
    write_tgt(1, 200);
    for (int i = 1; i <= 41; i++) begin
      sweep();
      e = (5 * i > 200) ? 200 : 5 * i;
      chk($sformatf("ramp_up_%0d", i), 32'(ch_val(1)), 32'(e));
    end
    chk("ramp_up_settled1", 32'(bus.settled[1]), 32'd1);
    chk("ramp_up_ch0_hold", 32'(ch_val(0)), 32'd0);

    // ch2 from 200 down to 3 by 15, final step clamps
    bus.bypass = 1;
    write_tgt(2, 200);
    sweep();
    chk("bypass_200", 32'(ch_val(2)), 32'd200);
    bus.bypass = 0; bus.fall_step = 15;
    write_tgt(2, 3);
    for (int i = 1; i <= 15; i++) begin
      sweep();
      e = (200 - 15 * i > 3) ? 200 - 15 * i : 3;
      chk($sformatf("ramp_dn_%0d", i), 32'(ch_val(2)), 32'(e));
    end

    // ch0 near the top: 250 -> 255 without wrap; bypass jump; zero step holds
    bus.bypass = 1;
    write_tgt(0, 250);
    sweep();
    bus.bypass = 0; bus.rise_step = 15;
    write_tgt(0, 255);
    sweep();
    chk("top_clamp", 32'(ch_val(0)), 32'd255);
    bus.bypass = 1;
    write_tgt(0, 17);
    sweep();
    chk("bypass_17", 32'(ch_val(0)), 32'd17);
    bus.bypass = 0; bus.rise_step = 0;
    write_tgt(0, 100);
    sweep();
    chk("zero_step_hold", 32'(ch_val(0)), 32'd17);
    chk("zero_step_unsettled", 32'(bus.settled[0]), 32'd0);

    // same-cycle write and tick: sweep uses the new target
    bus.rise_step = 15;
    bus.in_valid = 1; bus.in_ch = 3; bus.in_data = 9; bus.tick = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 6; i++) step();
    chk("write_with_tick", 32'(ch_val(3)), 32'd9);

    // reset in the cycle ptr=2 is processed; overrun set beforehand
    write_tgt(3, 200);
    bus.tick = 1;
    step();
    bus.tick = 1;
    step();
    bus.tick = 0;
    step();
    chk("pre_rst_overrun", 32'(bus.overrun), 32'd1);
    reset = 1;
    #1;
    chk("rst_in_ready_comb", 32'(bus.in_ready), 32'd0);
    step();
    reset = 0;
    #1;
    chk("midrst_busy",    32'(bus.busy),      32'd0);
    chk("midrst_upd",     32'(bus.upd_valid), 32'd0);
    chk("midrst_upd_ch",  32'(bus.upd_ch),    32'd0);
    chk("midrst_dout",    bus.data_out,       32'd0);
    chk("midrst_settled", 32'(bus.settled),   32'hF);
    chk("midrst_overrun", 32'(bus.overrun),   32'd0);
    chk("midrst_ready",   32'(bus.in_ready),  32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst_quiet_%0d", i), {30'd0, bus.upd_valid, bus.busy}, 32'd0);
    end
    chk("post_rst_dout", bus.data_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
